// File: rtl/swerv_types.sv
// Shared SweRV trace types: the core's per-cycle retire packet and the
// per-instruction record produced by the trace buffer.
// Latency: n/a (types only). Backpressure: n/a.
package swerv_types;

    localparam int TRACE_LANES = 3;

    // Per-cycle retire trace from the core, up to three instructions wide.
    typedef struct packed {
        logic [2:0]  trace_rv_i_valid_ip;
        logic [95:0] trace_rv_i_insn_ip;
        logic [95:0] trace_rv_i_address_ip;
        logic [2:0]  trace_rv_i_exception_ip;
        logic [4:0]  trace_rv_i_ecause_ip;
        logic [2:0]  trace_rv_i_interrupt_ip;
        logic [31:0] trace_rv_i_tval_ip;
    } trace_pkt_t;

    // One retired instruction as seen by the trace sink.
    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
        logic [31:0] tval;
    } trace_rec_t;

endpackage

// File: rtl/swerv_trace_unpack.sv
// Unpacks a trace packet into up to three records compacted in lane order.
// Latency: purely combinational. Backpressure: none, caller decides acceptance.
// Ports: trace_pkt_i packet in; rec_o compacted records (slot 0 = lowest valid lane); n_o valid-lane count.
module swerv_trace_unpack
    import swerv_types::*;
(
    input  trace_pkt_t                    trace_pkt_i,
    output trace_rec_t [TRACE_LANES-1:0]  rec_o,
    output logic [1:0]                    n_o
);

    trace_rec_t lane_rec;
    logic [1:0] slot;

    always_comb begin
        rec_o    = '0;
        lane_rec = '0;
        slot     = 2'd0;
        for (int i = 0; i < TRACE_LANES; i++) begin
            lane_rec.insn = trace_pkt_i.trace_rv_i_insn_ip[32*i +: 32];
            lane_rec.addr = trace_pkt_i.trace_rv_i_address_ip[32*i +: 32];
            lane_rec.exc  = trace_pkt_i.trace_rv_i_exception_ip[i];
            lane_rec.intr = trace_pkt_i.trace_rv_i_interrupt_ip[i];
            // ecause/tval are shared by all lanes; only the trapping lane owns them.
            if (lane_rec.exc | lane_rec.intr) begin
                lane_rec.ecause = trace_pkt_i.trace_rv_i_ecause_ip;
                lane_rec.tval   = trace_pkt_i.trace_rv_i_tval_ip;
            end else begin
                lane_rec.ecause = '0;
                lane_rec.tval   = '0;
            end
            if (trace_pkt_i.trace_rv_i_valid_ip[i]) begin
                rec_o[slot] = lane_rec;
                slot        = slot + 2'd1;
            end
        end
    end

    assign n_o = {1'b0, trace_pkt_i.trace_rv_i_valid_ip[0]}
               + {1'b0, trace_pkt_i.trace_rv_i_valid_ip[1]}
               + {1'b0, trace_pkt_i.trace_rv_i_valid_ip[2]};

endmodule

// File: rtl/swerv_trace_buf.sv
// Buffers retired-instruction trace records and streams them one per cycle to a sink.
// Latency: a record written at edge N is presented at rec_out from cycle N+1.
// Backpressure: valid/ready on the output; packets that do not fit whole are dropped and counted.
// Ports: clk/rst (async, active-high); trace_en, trace_pkt in; clr_ovf clears overflow state;
//        rec_valid/rec_ready/rec_out sink port; fifo_cnt occupancy; ovf_sticky, drop_cnt overflow status.
module swerv_trace_buf
    import swerv_types::*;
#(
    parameter int DEPTH  = 8,
    parameter int DCNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    input  trace_pkt_t               trace_pkt,
    input  logic                     clr_ovf,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output trace_rec_t               rec_out,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     ovf_sticky,
    output logic [DCNT_W-1:0]        drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    trace_rec_t [TRACE_LANES-1:0] lane_recs;
    logic [1:0]                   lane_n;
    logic [1:0]                   n_eff;

    trace_rec_t        mem_q [DEPTH];
    trace_rec_t        last_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [DCNT_W-1:0] drop_q, drop_d;

    logic [CW-1:0]     free;
    logic              push, drop, pop;

    swerv_trace_unpack u_unpack (
        .trace_pkt_i (trace_pkt),
        .rec_o       (lane_recs),
        .n_o         (lane_n)
    );

    assign n_eff = trace_en ? lane_n : 2'd0;

    // Space is judged on the pre-pop count, so a same-cycle pop never makes room.
    assign free = CW'(DEPTH) - cnt_q;
    assign push = (n_eff != 2'd0) && (free >= CW'(n_eff));
    assign drop = (n_eff != 2'd0) && !push;
    assign pop  = (cnt_q != '0) && rec_ready;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(n_eff) : wr_ptr_q;
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + (push ? CW'(n_eff) : CW'(0)) - CW'(pop);

        // A drop in the same cycle as a clear leaves a count of exactly one.
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (clr_ovf)
                drop_d = DCNT_W'(1);
            else if (!(&drop_q))
                drop_d = drop_q + DCNT_W'(1);
        end else if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            if (pop)
                last_q <= mem_q[rd_ptr_q];
        end
    end

    // Storage needs no reset: nothing is visible unless the count says it is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int k = 0; k < TRACE_LANES; k++) begin
                if (2'(k) < n_eff)
                    mem_q[wr_ptr_q + AW'(k)] <= lane_recs[k];
            end
        end
    end

    assign rec_valid  = (cnt_q != '0);
    // When empty, keep showing the last record handed to the sink.
    assign rec_out    = rec_valid ? mem_q[rd_ptr_q] : last_q;
    assign fifo_cnt   = cnt_q;
    assign ovf_sticky = ovf_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_swerv_trace_buf.sv
module tb_swerv_trace_buf;
    import swerv_types::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       trace_en;
    trace_pkt_t trace_pkt;
    logic       clr_ovf;
    logic       rec_valid;
    logic       rec_ready;
    trace_rec_t rec_out;
    logic [3:0] fifo_cnt;
    logic       ovf_sticky;
    logic [3:0] drop_cnt;

    trace_rec_t exp_q[$];
    trace_rec_t mon_e;
    int n_chk  = 0;
    int n_pass = 0;

    swerv_trace_buf #(.DEPTH(8), .DCNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .trace_en   (trace_en),
        .trace_pkt  (trace_pkt),
        .clr_ovf    (clr_ovf),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_out    (rec_out),
        .fifo_cnt   (fifo_cnt),
        .ovf_sticky (ovf_sticky),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic trace_rec_t rec(input logic [31:0] insn, input logic [31:0] addr,
                                       input logic exc, input logic intr,
                                       input logic [4:0] ec, input logic [31:0] tv);
        trace_rec_t r;
        r.insn = insn; r.addr = addr; r.exc = exc; r.intr = intr; r.ecause = ec; r.tval = tv;
        return r;
    endfunction

    // Lane k carries insn ib+k at address ab+4k.
    function automatic trace_pkt_t mkpkt(input logic [2:0] v, input logic [31:0] ib, input logic [31:0] ab,
                                         input logic [2:0] ex, input logic [2:0] it,
                                         input logic [4:0] ec, input logic [31:0] tv);
        trace_pkt_t p;
        p = '0;
        p.trace_rv_i_valid_ip = v;
        for (int k = 0; k < 3; k++) begin
            p.trace_rv_i_insn_ip[32*k +: 32]    = ib + 32'(k);
            p.trace_rv_i_address_ip[32*k +: 32] = ab + 32'(4*k);
        end
        p.trace_rv_i_exception_ip = ex;
        p.trace_rv_i_interrupt_ip = it;
        p.trace_rv_i_ecause_ip    = ec;
        p.trace_rv_i_tval_ip      = tv;
        return p;
    endfunction

    // Expected records for a plain (no trap) packet, lowest lane first.
    task automatic expl(input logic [2:0] v, input logic [31:0] ib, input logic [31:0] ab);
        for (int k = 0; k < 3; k++)
            if (v[k]) exp_q.push_back(rec(ib + 32'(k), ab + 32'(4*k), 1'b0, 1'b0, 5'd0, 32'd0));
    endtask

    task automatic cyc(input trace_pkt_t p, input logic en, input logic rdy, input logic clr);
        trace_pkt = p; trace_en = en; rec_ready = rdy; clr_ovf = clr;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int cnt, input logic rdy);
        for (int i = 0; i < cnt; i++) cyc('0, 1'b1, rdy, 1'b0);
    endtask

    // Monitor: every accepted output record must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL rec_unexpected: got %0h expected no record", rec_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rec_out", rec_out, mon_e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    logic [2:0] vtab [6];
    int mcnt, mdrop, n, pop;
    logic [2:0] v;
    logic en, rdy, acc;

    initial begin
        vtab[0] = 3'b011; vtab[1] = 3'b100; vtab[2] = 3'b000;
        vtab[3] = 3'b111; vtab[4] = 3'b001; vtab[5] = 3'b110;

        rst = 1'b1; trace_en = 1'b0; trace_pkt = '0; rec_ready = 1'b0; clr_ovf = 1'b0;
        #12;
        chk("rst_rec_valid", rec_valid, 0);
        chk("rst_rec_out", rec_out, 0);
        chk("rst_fifo_cnt", fifo_cnt, 0);
        chk("rst_ovf", ovf_sticky, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Single lane, sink always ready
        exp_q.push_back(rec(32'h00A00093, 32'h80000000, 1'b0, 1'b0, 5'd0, 32'd0));
        cyc(mkpkt(3'b001, 32'h00A00093, 32'h80000000, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b1, 1'b0);
        chk("single_cnt1", fifo_cnt, 1);
        chk("single_valid1", rec_valid, 1);
        idle(1, 1'b1);
        chk("single_cnt0", fifo_cnt, 0);
        chk("single_valid0", rec_valid, 0);
        chk("empty_holds_last", rec_out.insn, 32'h00A00093);

        // Lane order with a hole in the middle
        exp_q.push_back(rec(32'h11, 32'h100, 1'b0, 1'b0, 5'd0, 32'd0));
        exp_q.push_back(rec(32'h13, 32'h108, 1'b0, 1'b0, 5'd0, 32'd0));
        cyc(mkpkt(3'b101, 32'h11, 32'h100, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b0, 1'b0);
        chk("order_cnt", fifo_cnt, 2);
        idle(2, 1'b1);
        chk("order_drained", fifo_cnt, 0);

        // Exception on lane 1 only owns ecause/tval
        exp_q.push_back(rec(32'h20, 32'h200, 1'b0, 1'b0, 5'd0, 32'd0));
        exp_q.push_back(rec(32'h21, 32'h204, 1'b1, 1'b0, 5'd2, 32'hDEAD));
        cyc(mkpkt(3'b011, 32'h20, 32'h200, 3'b010, 3'b000, 5'd2, 32'hDEAD), 1'b1, 1'b0, 1'b0);
        chk("exc_cnt", fifo_cnt, 2);
        idle(2, 1'b1);

        // Exception on lane 0, interrupt on lane 2
        exp_q.push_back(rec(32'h30, 32'h300, 1'b1, 1'b0, 5'd3, 32'h1234));
        exp_q.push_back(rec(32'h31, 32'h304, 1'b0, 1'b0, 5'd0, 32'd0));
        exp_q.push_back(rec(32'h32, 32'h308, 1'b0, 1'b1, 5'd3, 32'h1234));
        cyc(mkpkt(3'b111, 32'h30, 32'h300, 3'b001, 3'b100, 5'd3, 32'h1234), 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        chk("intr_drained", fifo_cnt, 0);

        // Overflow: third 3-lane packet does not fit in the 2 free slots
        expl(3'b111, 32'h40, 32'h400);
        expl(3'b111, 32'h50, 32'h500);
        cyc(mkpkt(3'b111, 32'h40, 32'h400, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b0, 1'b0);
        cyc(mkpkt(3'b111, 32'h50, 32'h500, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b0, 1'b0);
        cyc(mkpkt(3'b111, 32'h60, 32'h600, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b0, 1'b0);
        chk("ovf_cnt", fifo_cnt, 6);
        chk("ovf_sticky", ovf_sticky, 1);
        chk("ovf_drop_cnt", drop_cnt, 1);
        idle(6, 1'b1);
        chk("ovf_drained", fifo_cnt, 0);
        cyc('0, 1'b1, 1'b0, 1'b1);
        chk("clr_ovf", ovf_sticky, 0);
        chk("clr_drop_cnt", drop_cnt, 0);

        // Boundary at 7 entries: pop never frees a slot for the same-cycle push
        expl(3'b111, 32'h70, 32'h700);
        expl(3'b111, 32'h80, 32'h800);
        expl(3'b001, 32'h90, 32'h900);
        expl(3'b001, 32'hA0, 32'hA00);
        cyc(mkpkt(3'b111, 32'h70, 32'h700, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b0, 1'b0);
        cyc(mkpkt(3'b111, 32'h80, 32'h800, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b0, 1'b0);
        cyc(mkpkt(3'b001, 32'h90, 32'h900, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b0, 1'b0);
        chk("bnd_cnt7", fifo_cnt, 7);
        cyc(mkpkt(3'b001, 32'hA0, 32'hA00, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b1, 1'b0);
        chk("bnd_push_pop_cnt", fifo_cnt, 7);
        chk("bnd_no_drop", drop_cnt, 0);
        cyc(mkpkt(3'b011, 32'hB0, 32'hB00, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b1, 1'b0);
        chk("bnd_drop_cnt6", fifo_cnt, 6);
        chk("bnd_drop", drop_cnt, 1);
        idle(6, 1'b1);
        chk("bnd_drained", fifo_cnt, 0);
        cyc('0, 1'b1, 1'b0, 1'b1);

        // Mixed traffic across pointer wrap, acceptance from a small occupancy model
        mcnt = 0; mdrop = 0;
        for (int i = 0; i < 40; i++) begin
            v   = vtab[i % 6];
            en  = (i % 5 != 4);
            rdy = (i % 4 != 3);
            n   = en ? $countones(v) : 0;
            acc = (n > 0) && (8 - mcnt >= n);
            if (acc) expl(v, 32'h1000 + 32'(i*16), 32'h8000 + 32'(i*16));
            if (n > 0 && !acc && mdrop < 15) mdrop++;
            pop  = (mcnt != 0 && rdy) ? 1 : 0;
            mcnt = mcnt + (acc ? n : 0) - pop;
            cyc(mkpkt(v, 32'h1000 + 32'(i*16), 32'h8000 + 32'(i*16), 3'b0, 3'b0, 5'd0, 32'd0), en, rdy, 1'b0);
        end
        chk("mix_cnt", fifo_cnt, 128'(mcnt));
        chk("mix_drop", drop_cnt, 128'(mdrop));
        idle(10, 1'b1);
        chk("mix_drained", fifo_cnt, 0);
        cyc('0, 1'b1, 1'b0, 1'b1);

        // Drop counter saturation with a full FIFO
        expl(3'b111, 32'hC0, 32'hC00);
        expl(3'b111, 32'hD0, 32'hD00);
        expl(3'b011, 32'hE0, 32'hE00);
        cyc(mkpkt(3'b111, 32'hC0, 32'hC00, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b0, 1'b0);
        cyc(mkpkt(3'b111, 32'hD0, 32'hD00, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b0, 1'b0);
        cyc(mkpkt(3'b011, 32'hE0, 32'hE00, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b0, 1'b0);
        chk("full_cnt", fifo_cnt, 8);
        cyc(mkpkt(3'b000, 32'hF0, 32'hF00, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b0, 1'b0);
        chk("full_n0_nodrop", drop_cnt, 0);
        cyc(mkpkt(3'b111, 32'hF0, 32'hF00, 3'b0, 3'b0, 5'd0, 32'd0), 1'b0, 1'b0, 1'b0);
        chk("full_dis_nodrop", drop_cnt, 0);
        chk("full_dis_noovf", ovf_sticky, 0);
        for (int i = 0; i < 20; i++)
            cyc(mkpkt(3'b001, 32'hF0, 32'hF00, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b0, 1'b0);
        chk("sat_drop_cnt", drop_cnt, 15);
        chk("sat_ovf", ovf_sticky, 1);
        cyc(mkpkt(3'b001, 32'hF0, 32'hF00, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b0, 1'b1);
        chk("clr_and_drop_cnt", drop_cnt, 1);
        chk("clr_and_drop_ovf", ovf_sticky, 1);
        cyc('0, 1'b1, 1'b0, 1'b1);
        chk("clr_only_cnt", drop_cnt, 0);
        chk("full_cnt_kept", fifo_cnt, 8);

        // Asynchronous reset while full
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", rec_valid, 0);
        chk("arst_cnt", fifo_cnt, 0);
        chk("arst_rec_out", rec_out, 0);
        exp_q.delete();
        @(posedge clk); #1; rst = 1'b0;
        exp_q.push_back(rec(32'h1111, 32'h2222, 1'b0, 1'b0, 5'd0, 32'd0));
        cyc(mkpkt(3'b001, 32'h1111, 32'h2222, 3'b0, 3'b0, 5'd0, 32'd0), 1'b1, 1'b1, 1'b0);
        chk("post_rst_cnt", fifo_cnt, 1);
        idle(2, 1'b1);
        chk("post_rst_drained", fifo_cnt, 0);
        chk("scoreboard_empty", 128'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
